// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, request bundle and opcode check
// for the ALU sharing arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1111;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    localparam int unsigned ALU_W = 32;

    typedef struct packed {
        logic [3:0]       ctrl;
        logic [ALU_W-1:0] in1;
        logic [ALU_W-1:0] in2;
    } alu_req_t;

    function automatic logic alu_op_supported(input logic [3:0] ctrl);
        logic ok;
        unique case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD,
            ALU_SUB, ALU_XOR, ALU_SRL: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester port of the ALU arbiter: request handshake
// plus the 1-entry response slot handshake.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output valid, ctrl, in1, in2, rsp_ready,
        input  ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  valid, ctrl, in1, in2, rsp_ready,
        output ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way grant logic with a round-robin pointer; FAIR_MODE=0
// turns it into fixed priority with port 0 winning ties.
module rr_arb2 #(
    parameter int FAIR_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ((FAIR_MODE != 0) && ptr_q) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer favours the port that did not win last.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one integer ALU between the execute path (port 0) and
// the address/branch-target unit (port 1), 1-cycle result latency.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FAIR_MODE = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     rq0,
    alu_arbiter_if.slave     rq1,
    output logic             alu_en,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic [1:0] valid;
    logic [1:0] rsp_rdy;
    logic [1:0] sup;
    logic [1:0] req;
    logic [1:0] gnt;

    logic [1:0]       vld_q;
    logic [1:0]       vld_d;
    logic [1:0]       err_q;
    logic [1:0]       err_d;
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];

    assign valid   = {rq1.valid, rq0.valid};
    assign rsp_rdy = {rq1.rsp_ready, rq0.rsp_ready};
    assign sup[0]  = alu_op_supported(rq0.ctrl);
    assign sup[1]  = alu_op_supported(rq1.ctrl);

    // A port may issue when its slot is empty or draining now.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req[i] = rst_n & valid[i] & (~vld_q[i] | rsp_rdy[i]);
        end
    end

    rr_arb2 #(
        .FAIR_MODE (FAIR_MODE)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign rq0.ready = gnt[0];
    assign rq1.ready = gnt[1];

    always_comb begin
        alu_en   = 1'b0;
        alu_ctrl = '0;
        alu_in1  = '0;
        alu_in2  = '0;
        unique case (1'b1)
            gnt[0]: begin
                alu_en   = sup[0];
                alu_ctrl = rq0.ctrl;
                alu_in1  = rq0.in1;
                alu_in2  = rq0.in2;
            end
            gnt[1]: begin
                alu_en   = sup[1];
                alu_ctrl = rq1.ctrl;
                alu_in1  = rq1.in1;
                alu_in2  = rq1.in2;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            vld_d[i]  = vld_q[i];
            err_d[i]  = err_q[i];
            data_d[i] = data_q[i];
            if (gnt[i]) begin
                vld_d[i]  = 1'b1;
                err_d[i]  = ~sup[i];
                data_d[i] = sup[i] ? alu_out : '0;
            end else if (vld_q[i] && rsp_rdy[i]) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (gnt[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign rq0.rsp_valid = vld_q[0];
    assign rq1.rsp_valid = vld_q[1];
    assign rq0.rsp_err   = err_q[0];
    assign rq1.rsp_err   = err_q[1];
    assign rq0.rsp_data  = data_q[0];
    assign rq1.rsp_data  = data_q[1];
    assign gnt_cnt0      = cnt_q[0];
    assign gnt_cnt1      = cnt_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: round-robin instance with a
// response scoreboard, plus a fixed-priority instance with 2-bit counters.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) rq0 ();
    alu_arbiter_if #(.WIDTH(32)) rq1 ();
    alu_arbiter_if #(.WIDTH(32)) fq0 ();
    alu_arbiter_if #(.WIDTH(32)) fq1 ();

    logic        alu_en, f_alu_en;
    logic [3:0]  alu_ctrl, f_alu_ctrl;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [31:0] f_alu_in1, f_alu_in2, f_alu_out;
    logic        cnt_clr = 1'b0;
    logic        f_cnt_clr = 1'b0;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic [1:0]  f_cnt0, f_cnt1;

    int n_chk = 0;
    int n_pass = 0;
    int exp_ptr = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // Behavioural stand-in for the shared ALU.
    function automatic logic [31:0] alu_model(input logic [3:0] c,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SRL: return a >> b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out   = alu_model(alu_ctrl, alu_in1, alu_in2);
    assign f_alu_out = alu_model(f_alu_ctrl, f_alu_in1, f_alu_in2);

    alu_arbiter #(.WIDTH(32), .FAIR_MODE(1), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rq0      (rq0),
        .rq1      (rq1),
        .alu_en   (alu_en),
        .alu_ctrl (alu_ctrl),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_out  (alu_out),
        .cnt_clr  (cnt_clr),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    alu_arbiter #(.WIDTH(32), .FAIR_MODE(0), .CNT_W(2)) dut_fp (
        .clk      (clk),
        .rst_n    (rst_n),
        .rq0      (fq0),
        .rq1      (fq1),
        .alu_en   (f_alu_en),
        .alu_ctrl (f_alu_ctrl),
        .alu_in1  (f_alu_in1),
        .alu_in2  (f_alu_in2),
        .alu_out  (f_alu_out),
        .cnt_clr  (f_cnt_clr),
        .gnt_cnt0 (f_cnt0),
        .gnt_cnt1 (f_cnt1)
    );

    // Scoreboard: pop one expected result per consumed response.
    always @(negedge clk) begin
        if (rst_n && rq0.rsp_valid && rq0.rsp_ready) begin
            n_chk++;
            if (q0.size() == 0) begin
                $display("FAIL p0_rsp_unexpected got=%h/%b exp=none",
                         rq0.rsp_data, rq0.rsp_err);
            end else begin
                e0 = q0.pop_front();
                if ({rq0.rsp_data, rq0.rsp_err} !== {e0.data, e0.err})
                    $display("FAIL p0_rsp got=%h/%b exp=%h/%b",
                             rq0.rsp_data, rq0.rsp_err, e0.data, e0.err);
                else
                    n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rq1.rsp_valid && rq1.rsp_ready) begin
            n_chk++;
            if (q1.size() == 0) begin
                $display("FAIL p1_rsp_unexpected got=%h/%b exp=none",
                         rq1.rsp_data, rq1.rsp_err);
            end else begin
                e1 = q1.pop_front();
                if ({rq1.rsp_data, rq1.rsp_err} !== {e1.data, e1.err})
                    $display("FAIL p1_rsp got=%h/%b exp=%h/%b",
                             rq1.rsp_data, rq1.rsp_err, e1.data, e1.err);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rq0.valid = 1'b1; rq0.ctrl = ALU_ADD;
        rq1.valid = 1'b1; rq1.ctrl = ALU_ADD;
        fq0.valid = 1'b1; fq1.valid = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (rq0.ready !== 1'b0 || rq1.ready !== 1'b0)
            $display("FAIL rst_ready got=%b%b exp=00", rq1.ready, rq0.ready);
        else n_pass++;
        n_chk++;
        if (alu_en !== 1'b0 || f_alu_en !== 1'b0)
            $display("FAIL rst_alu_en got=%b/%b exp=0/0", alu_en, f_alu_en);
        else n_pass++;
        n_chk++;
        if ({rq0.rsp_valid, rq1.rsp_valid, rq0.rsp_err, rq1.rsp_err} !== 4'b0)
            $display("FAIL rst_rsp_flags got=%b%b%b%b exp=0000",
                     rq0.rsp_valid, rq1.rsp_valid, rq0.rsp_err, rq1.rsp_err);
        else n_pass++;
        n_chk++;
        if (rq0.rsp_data !== 32'h0 || rq1.rsp_data !== 32'h0)
            $display("FAIL rst_rsp_data got=%h/%h exp=0/0",
                     rq0.rsp_data, rq1.rsp_data);
        else n_pass++;
        n_chk++;
        if (gnt_cnt0 !== 16'h0 || gnt_cnt1 !== 16'h0)
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0", gnt_cnt0, gnt_cnt1);
        else n_pass++;
        rq0.valid = 1'b0; rq1.valid = 1'b0;
        fq0.valid = 1'b0; fq1.valid = 1'b0;
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_add();
        tick();
        rq0.valid = 1'b1; rq0.ctrl = ALU_ADD;
        rq0.in1 = 32'd5; rq0.in2 = 32'd7;
        @(negedge clk);
        n_chk++;
        if (rq0.ready !== 1'b1 || rq1.ready !== 1'b0)
            $display("FAIL add_ready got=%b%b exp=01", rq1.ready, rq0.ready);
        else n_pass++;
        n_chk++;
        if ({alu_en, alu_ctrl, alu_in1, alu_in2} !== {1'b1, ALU_ADD, 32'd5, 32'd7})
            $display("FAIL add_alu_drive got=%b/%h/%h/%h exp=1/2/5/7",
                     alu_en, alu_ctrl, alu_in1, alu_in2);
        else n_pass++;
        q0.push_back('{data: 32'd12, err: 1'b0});
        exp_ptr = 1;
        tick();
        rq0.valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({rq0.rsp_valid, rq0.rsp_data, rq0.rsp_err} !== {1'b1, 32'd12, 1'b0})
            $display("FAIL add_rsp got=%b/%h/%b exp=1/0000000c/0",
                     rq0.rsp_valid, rq0.rsp_data, rq0.rsp_err);
        else n_pass++;
        n_chk++;
        if ({alu_en, alu_ctrl, alu_in1, alu_in2} !== '0)
            $display("FAIL idle_alu_quiet got=%b/%h/%h/%h exp=0/0/0/0",
                     alu_en, alu_ctrl, alu_in1, alu_in2);
        else n_pass++;
        tick();
        rq0.rsp_ready = 1'b1; rq1.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (rq0.rsp_valid !== 1'b0)
            $display("FAIL add_drain got=%b exp=0", rq0.rsp_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] a0, b0, a1, b1;
        int win;
        tick();
        rq1.valid = 1'b1; rq1.ctrl = ALU_ADD;
        rq1.in1 = 32'd1; rq1.in2 = 32'd1;
        @(negedge clk);
        n_chk++;
        if (rq1.ready !== 1'b1)
            $display("FAIL rr_solo_p1 got=%b exp=1", rq1.ready);
        else n_pass++;
        q1.push_back('{data: 32'd2, err: 1'b0});
        exp_ptr = 0;
        tick();
        rq1.valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        n_chk++;
        if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0)
            $display("FAIL cnt_clr got=%0d/%0d exp=0/0", gnt_cnt0, gnt_cnt1);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            rq0.valid = 1'b1; rq0.ctrl = ALU_ADD; rq0.in1 = a0; rq0.in2 = b0;
            rq1.valid = 1'b1; rq1.ctrl = ALU_ADD; rq1.in1 = a1; rq1.in2 = b1;
            @(negedge clk);
            win = exp_ptr;
            n_chk++;
            if (rq0.ready !== (win == 0) || rq1.ready !== (win == 1))
                $display("FAIL rr_grant%0d got=%b%b exp_port=%0d",
                         k, rq1.ready, rq0.ready, win);
            else n_pass++;
            if (win == 0) q0.push_back('{data: a0 + b0, err: 1'b0});
            else          q1.push_back('{data: a1 + b1, err: 1'b0});
            exp_ptr = 1 - win;
        end
        tick();
        rq0.valid = 1'b0; rq1.valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2)
            $display("FAIL rr_cnt got=%0d/%0d exp=2/2", gnt_cnt0, gnt_cnt1);
        else n_pass++;
    endtask

    task automatic test_fixed();
        fq0.rsp_ready = 1'b1; fq1.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            fq0.valid = 1'b1; fq0.ctrl = ALU_ADD; fq0.in1 = k; fq0.in2 = 32'd1;
            fq1.valid = 1'b1; fq1.ctrl = ALU_ADD; fq1.in1 = k; fq1.in2 = 32'd2;
            @(negedge clk);
            n_chk++;
            if (fq0.ready !== 1'b1 || fq1.ready !== 1'b0)
                $display("FAIL fp_grant%0d got=%b%b exp=01",
                         k, fq1.ready, fq0.ready);
            else n_pass++;
        end
        tick();
        fq0.valid = 1'b0; fq1.valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (f_cnt0 !== 2'd3 || f_cnt1 !== 2'd0)
            $display("FAIL fp_cnt_sat got=%0d/%0d exp=3/0", f_cnt0, f_cnt1);
        else n_pass++;
        tick();
        fq0.valid = 1'b1;
        f_cnt_clr = 1'b1;
        @(negedge clk);
        n_chk++;
        if (fq0.ready !== 1'b1)
            $display("FAIL fp_clr_grant got=%b exp=1", fq0.ready);
        else n_pass++;
        tick();
        fq0.valid = 1'b0;
        f_cnt_clr = 1'b0;
        @(negedge clk);
        n_chk++;
        if (f_cnt0 !== 2'd0)
            $display("FAIL fp_clr_priority got=%0d exp=0", f_cnt0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        tick();
        rq0.rsp_ready = 1'b0;
        rq0.valid = 1'b1; rq0.ctrl = ALU_OR;
        rq0.in1 = 32'h0000_00F0; rq0.in2 = 32'h0000_0F00;
        @(negedge clk);
        n_chk++;
        if (rq0.ready !== 1'b1)
            $display("FAIL bp_first got=%b exp=1", rq0.ready);
        else n_pass++;
        q0.push_back('{data: 32'h0000_0FF0, err: 1'b0});
        exp_ptr = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            rq0.ctrl = ALU_ADD; rq0.in1 = 32'd9; rq0.in2 = 32'd9;
            rq1.valid = 1'b1; rq1.ctrl = ALU_ADD;
            rq1.in1 = k; rq1.in2 = 32'd10;
            @(negedge clk);
            n_chk++;
            if (rq0.ready !== 1'b0 || rq1.ready !== 1'b1)
                $display("FAIL bp_grant%0d got=%b%b exp=10",
                         k, rq1.ready, rq0.ready);
            else n_pass++;
            n_chk++;
            if (rq0.rsp_data !== 32'h0000_0FF0 || rq0.rsp_valid !== 1'b1)
                $display("FAIL bp_hold%0d got=%b/%h exp=1/00000ff0",
                         k, rq0.rsp_valid, rq0.rsp_data);
            else n_pass++;
            q1.push_back('{data: k + 10, err: 1'b0});
            exp_ptr = 0;
        end
        tick();
        rq0.rsp_ready = 1'b1;
        rq0.in1 = 32'd100; rq0.in2 = 32'd200;
        @(negedge clk);
        n_chk++;
        if (rq0.ready !== 1'b1 || rq1.ready !== 1'b0)
            $display("FAIL bp_release got=%b%b exp=01", rq1.ready, rq0.ready);
        else n_pass++;
        q0.push_back('{data: 32'd300, err: 1'b0});
        exp_ptr = 1;
        tick();
        rq0.valid = 1'b0; rq1.valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rq0.rsp_data !== 32'd300 || rq0.rsp_valid !== 1'b1)
            $display("FAIL bp_replace got=%b/%h exp=1/0000012c",
                     rq0.rsp_valid, rq0.rsp_data);
        else n_pass++;
    endtask

    task automatic test_unsupported();
        tick();
        rq1.valid = 1'b1; rq1.ctrl = 4'b0011;
        rq1.in1 = 32'h1234_5678; rq1.in2 = 32'h1;
        @(negedge clk);
        n_chk++;
        if (rq1.ready !== 1'b1 || alu_en !== 1'b0)
            $display("FAIL unsup_issue got=rdy%b/en%b exp=rdy1/en0",
                     rq1.ready, alu_en);
        else n_pass++;
        q1.push_back('{data: 32'h0, err: 1'b1});
        exp_ptr = 0;
        tick();
        rq1.valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({rq1.rsp_valid, rq1.rsp_err, rq1.rsp_data} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL unsup_rsp got=%b/%b/%h exp=1/1/00000000",
                     rq1.rsp_valid, rq1.rsp_err, rq1.rsp_data);
        else n_pass++;
        tick();
        rq0.valid = 1'b1; rq0.ctrl = ALU_ADD; rq0.in1 = 32'd1; rq0.in2 = 32'd2;
        rq1.valid = 1'b1; rq1.ctrl = ALU_ADD; rq1.in1 = 32'd3; rq1.in2 = 32'd4;
        @(negedge clk);
        n_chk++;
        if (rq0.ready !== (exp_ptr == 0) || rq1.ready !== (exp_ptr == 1))
            $display("FAIL unsup_ptr got=%b%b exp_port=%0d",
                     rq1.ready, rq0.ready, exp_ptr);
        else n_pass++;
        q0.push_back('{data: 32'd3, err: 1'b0});
        exp_ptr = 1;
        tick();
        rq0.valid = 1'b0; rq1.valid = 1'b0;
    endtask

    task automatic test_ops();
        logic [3:0]  c [6];
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [31:0] r [6];
        c[0] = ALU_SUB; a[0] = 32'd3;          b[0] = 32'd5;          r[0] = 32'hFFFF_FFFE;
        c[1] = ALU_SRL; a[1] = 32'h8000_0000;  b[1] = 32'd4;          r[1] = 32'h0800_0000;
        c[2] = ALU_XOR; a[2] = 32'hF0F0_F0F0;  b[2] = 32'hFFFF_0000;  r[2] = 32'h0F0F_F0F0;
        c[3] = ALU_AND; a[3] = 32'hF0F0_F0F0;  b[3] = 32'hFFFF_0000;  r[3] = 32'hF0F0_0000;
        c[4] = ALU_OR;  a[4] = 32'hF0F0_F0F0;  b[4] = 32'h0000_FFFF;  r[4] = 32'hF0F0_FFFF;
        c[5] = ALU_SRL; a[5] = 32'hFFFF_FFFF;  b[5] = 32'd40;         r[5] = 32'h0;
        for (int k = 0; k < 6; k++) begin
            tick();
            rq0.valid = 1'b1; rq0.ctrl = c[k]; rq0.in1 = a[k]; rq0.in2 = b[k];
            @(negedge clk);
            n_chk++;
            if (rq0.ready !== 1'b1 || alu_en !== 1'b1 || alu_ctrl !== c[k])
                $display("FAIL op%0d_issue got=rdy%b/en%b/ctrl%h exp=rdy1/en1/ctrl%h",
                         k, rq0.ready, alu_en, alu_ctrl, c[k]);
            else n_pass++;
            q0.push_back('{data: r[k], err: 1'b0});
            exp_ptr = 1;
        end
        tick();
        rq0.valid = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        rq1.rsp_ready = 1'b0;
        rq1.valid = 1'b1; rq1.ctrl = ALU_ADD; rq1.in1 = 32'd20; rq1.in2 = 32'd22;
        @(negedge clk);
        n_chk++;
        if (rq1.ready !== 1'b1)
            $display("FAIL ar_issue got=%b exp=1", rq1.ready);
        else n_pass++;
        q1.push_back('{data: 32'd42, err: 1'b0});
        tick();
        rq1.valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rq1.rsp_valid !== 1'b1 || rq1.rsp_data !== 32'd42)
            $display("FAIL ar_pending got=%b/%h exp=1/0000002a",
                     rq1.rsp_valid, rq1.rsp_data);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (rq1.rsp_valid !== 1'b0 || rq1.rsp_data !== 32'h0 || gnt_cnt1 !== 16'h0)
            $display("FAIL ar_async got=%b/%h/%0d exp=0/00000000/0",
                     rq1.rsp_valid, rq1.rsp_data, gnt_cnt1);
        else n_pass++;
        q1.delete();
        exp_ptr = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        rq1.rsp_ready = 1'b1;
        rq0.valid = 1'b1; rq0.ctrl = ALU_SUB; rq0.in1 = 32'd50; rq0.in2 = 32'd8;
        rq1.valid = 1'b1; rq1.ctrl = ALU_ADD; rq1.in1 = 32'd1; rq1.in2 = 32'd1;
        @(negedge clk);
        n_chk++;
        if (rq0.ready !== 1'b1 || rq1.ready !== 1'b0)
            $display("FAIL ar_first_grant got=%b%b exp=01", rq1.ready, rq0.ready);
        else n_pass++;
        q0.push_back('{data: 32'd42, err: 1'b0});
        exp_ptr = 1;
        tick();
        rq0.valid = 1'b0; rq1.valid = 1'b0;
    endtask

    initial begin
        rq0.valid = 1'b0; rq0.ctrl = '0; rq0.in1 = '0; rq0.in2 = '0; rq0.rsp_ready = 1'b0;
        rq1.valid = 1'b0; rq1.ctrl = '0; rq1.in1 = '0; rq1.in2 = '0; rq1.rsp_ready = 1'b0;
        fq0.valid = 1'b0; fq0.ctrl = '0; fq0.in1 = '0; fq0.in2 = '0; fq0.rsp_ready = 1'b0;
        fq1.valid = 1'b0; fq1.ctrl = '0; fq1.in1 = '0; fq1.in2 = '0; fq1.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_round_robin();
        test_fixed();
        test_backpressure();
        test_unsupported();
        test_ops();
        test_async_reset();
        repeat (4) @(negedge clk);
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL sb_leftover got=%0d/%0d exp=0/0", q0.size(), q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single integer ALU instance between two requesters: port 0 is the core execute path, port 1 is the address/branch-target unit.
- Arbitration is round-robin (or fixed priority) with a valid/ready request handshake per port.
- The selected operands drive the ALU combinationally; each result is captured into a per-port 1-entry response register.
- Sits beside the ALU at core top level. Drives the ALU's en/ctrl/in1/in2 inputs and consumes its out.

Parameters:
- WIDTH, 32, operand/result width.
- FAIR_MODE, 1: 1 = round-robin; 0 = fixed priority, port 0 always wins.
- CNT_W, 16, width of the per-port grant counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- r0_valid / r1_valid  in  1  request valid.
- r0_ready / r1_ready  out  1  request accepted this cycle.
- r0_ctrl / r1_ctrl  in  4  ALU op code.
- r0_in1, r0_in2 / r1_in1, r1_in2  in  WIDTH  operands.
- p0_rsp_valid / p1_rsp_valid  out  1  response valid.
- p0_rsp_ready / p1_rsp_ready  in  1  response consumed.
- p0_rsp_data / p1_rsp_data  out  WIDTH  result.
- p0_rsp_err / p1_rsp_err  out  1  unsupported op code.
- alu_en  out  1  ALU enable.
- alu_ctrl  out  4  to ALU.
- alu_in1, alu_in2  out  WIDTH  to ALU.
- alu_out  in  WIDTH  from ALU.
- cnt_clr  in  1  synchronous clear of grant counters.
- gnt_cnt0 / gnt_cnt1  out  CNT_W  saturating grant counts.

Behaviour:
- Reset (rst_n low, async):
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - Round-robin pointer = 0 (port 0 favoured first). Counters = 0.
  - r*_ready = 0 and alu_en = 0 while rst_n is low.
  - Pending responses are discarded.
- Eligibility: port i is eligible when ri_valid && (!pi_rsp_valid || pi_rsp_ready), i.e. its response slot is free or draining this cycle.
- Grant:
  - Exactly one eligible port: it wins.
  - Both eligible, FAIR_MODE=1: the pointer's port wins.
  - Both eligible, FAIR_MODE=0: port 0 wins.
- Pointer update: after any grant to port i, pointer = 1-i. With no grant, the pointer holds.
- ri_ready = grant_i. Combinational from valid/rsp_ready. Requesters must not make valid depend on ready.
- Issue cycle N (grant to i, supported ctrl):
  - alu_en = 1; alu_ctrl/in1/in2 = port i fields.
  - At the end of N: pi_rsp_data <= alu_out, pi_rsp_err <= 0, pi_rsp_valid <= 1.
  - Latency: 1 cycle.
- Supported ctrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 XOR, 1110 SRL.
- Unsupported ctrl: request is still accepted and the pointer still advances.
  - alu_en = 0.
  - Next cycle: pi_rsp_data = 0, pi_rsp_err = 1.
- No grant: alu_en = 0 and alu_ctrl/in1/in2 = 0 (no operand toggling).
- Response slot:
  - Clears on pi_rsp_valid && pi_rsp_ready with no new grant.
  - Drain and new grant in the same cycle: valid stays 1 and data is replaced.
  - While valid && !ready, data/err hold stable.
- Counters: gnt_cnti increments on each grant to port i and saturates at all-ones. cnt_clr has priority over increment.
- Datapath:
  - Operands pass through unmodified.
  - The arbiter adds no logic between alu_out and the capture register.
  - SRL semantics are those of the ALU: full in2 shift, so in2 ≥ 32 gives 0.

Decomposition:
- Package alu_pkg:
  - localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SRL.
  - Function alu_op_supported(ctrl).
  - typedef struct alu_req_t {ctrl, in1, in2}.
- Sub-module rr_arb2: 2-way grant logic plus pointer register, with FAIR_MODE parameter. Inputs req[1:0]; output gnt[1:0] (one-hot or zero).
- Response registers and counters stay in alu_arbiter.

Test Plan:
- Reset then port 0 ADD 5 + 7 -> r0_ready=1 in issue cycle; alu_en=1; next cycle p0_rsp_valid=1, data=12, err=0.
- Both valid continuously with rsp_ready=1 for 4 cycles, FAIR_MODE=1 -> grants 0,1,0,1; gnt_cnt0=2, gnt_cnt1=2. With FAIR_MODE=0 -> all 4 to port 0; r1_ready stays 0.
- p0 holds a result with p0_rsp_ready=0, both requesting -> r0_ready=0 and port 1 granted every cycle; p0_rsp_data stable. Raise p0_rsp_ready -> port 0 granted in that same cycle.
- Port 1 ctrl=4'b0011 -> alu_en=0; next cycle p1_rsp_err=1, p1_rsp_data=0; pointer advanced to 0.
- Op coverage: SUB 3 - 5 -> 0xFFFFFFFE; SRL 0x80000000 by 4 -> 0x08000000; XOR 0xF0F0F0F0 ^ 0xFFFF0000 -> 0x0F0FF0F0; AND/OR likewise.
- rst_n pulled low mid-cycle with p1_rsp_valid=1 -> p1_rsp_valid drops immediately (no clock edge needed). After release, both ports requesting -> port 0 granted first.
